// File: rtl/byte_word_assembler_pkg.sv
// Shared types and constants for the byte-serial receive path: FSM states,
// lane geometry and the little-endian lane insert helper.
package byte_word_assembler_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE,
        CHECK
    } state_t;

    // Returns w with lane idx replaced by b; lane 0 is bits 7:0.
    function automatic logic [WORD_W-1:0] lane_insert(
        input logic [WORD_W-1:0] w,
        input logic [IDX_W-1:0]  idx,
        input logic [BYTE_W-1:0] b
    );
        logic [WORD_W-1:0] r;
        r = w;
        r[BYTE_W*idx +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/byte_word_assembler_shift_reg.sv
// 4-lane little-endian byte assembler with clear and lane index.
// word_next shows the word as it would be after loading din, so the caller can
// capture the complete word on the same edge the final byte arrives.
module byte_shift_reg
    import byte_word_assembler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] din,
    output logic [WORD_W-1:0] word_next,
    output logic              last
);

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx;

    assign word_next = lane_insert(word_q, idx, din);
    assign last      = (idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
            idx    <= '0;
        end else if (load) begin
            word_q <= word_next;
            // wraps to lane 0 after the fourth byte
            idx    <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/byte_word_assembler.sv
// Assembles a byte stream into 32-bit little-endian words and writes them to
// RAM at auto-incrementing addresses. Optional trailing checksum: CHECKSUM_EN.
module byte_word_assembler
    import byte_word_assembler_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
`ifdef CHECKSUM_EN
    output logic              csum_err,
`endif
    output logic [ADDR_W:0]   words_written
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    state_t            state;
    logic              xfer;
    logic              load;
    logic              clear;
    logic              last;
    logic [WORD_W-1:0] word_next;

`ifdef CHECKSUM_EN
    logic [BYTE_W-1:0] csum_acc;
`endif

    assign xfer  = byte_valid && byte_ready;
    assign load  = xfer && (state == COLLECT);
    assign clear = start && (state == IDLE);

    byte_shift_reg u_shift (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .din       (byte_data),
        .word_next (word_next),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            byte_ready    <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
`ifdef CHECKSUM_EN
            csum_acc      <= '0;
            csum_err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr      <= base_addr;
                        words_written <= '0;
                        byte_ready    <= 1'b1;
                        busy          <= 1'b1;
                        state         <= COLLECT;
`ifdef CHECKSUM_EN
                        csum_acc      <= '0;
                        csum_err      <= 1'b0;
`endif
                    end
                end

                COLLECT: begin
                    if (xfer) begin
`ifdef CHECKSUM_EN
                        csum_acc <= csum_acc ^ byte_data;
`endif
                        if (last) begin
                            // drop ready now so the WRITE cycle back-pressures the link
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_wdata  <= word_next;
                            if (words_written != MAX_CNT) begin
                                words_written <= words_written + (ADDR_W + 1)'(1);
                            end
                            state      <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    mem_we   <= 1'b0;
                    mem_addr <= mem_addr + ADDR_W'(1);
                    if (words_written == MAX_CNT) begin
`ifdef CHECKSUM_EN
                        byte_ready <= 1'b1;
                        state      <= CHECK;
`else
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
`endif
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= COLLECT;
                    end
                end

`ifdef CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        csum_err   <= (byte_data != csum_acc);
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
`endif

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_word_assembler.sv
// Bench for byte_word_assembler: table vectors, latency/back-pressure and reset
// corner sequences, then randomized sessions checked against a write scoreboard.
module tb_byte_word_assembler;

    localparam int ADDR_W    = 5;
    localparam int MAX_WORDS = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;
`ifdef CHECKSUM_EN
    logic              csum_err;
    bit                csum_corrupt;
`endif

    byte_word_assembler #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
`ifdef CHECKSUM_EN
        .csum_err      (csum_err),
`endif
        .words_written (words_written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [4:0]  base;
        logic [63:0] bytes;   // byte 0 in bits 7:0
        logic [4:0]  a0;
        logic [31:0] w0;
        logic [4:0]  a1;
        logic [31:0] w1;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[3];
    int   errors;
    int   checks;
    int   stall_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    // Every wait goes through here so writes are scored on every cycle.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (busy && byte_valid && !byte_ready) stall_cnt++;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", mem_wdata, e.d);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (!byte_ready) begin
            bound_fail("byte_accept");
            byte_valid = 1'b0;
        end else begin
            tick();
        end
    endtask

    task automatic run_session(input logic [4:0] base, input logic [63:0] bytes,
                               input bit gaps, input bit noise, input bit lat);
        int n;
`ifdef CHECKSUM_EN
        logic [7:0] x;
`endif
        stall_cnt = 0;
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
        base_addr = 5'($urandom);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
                tick();
            end
            if (noise && (i == 2 || i == 5)) begin
                byte_valid = 1'b0;
                start      = 1'b1;
                base_addr  = 5'($urandom);
                tick();
                start      = 1'b0;
            end
            send_byte(bytes[8*i +: 8]);
            if (lat && i == 3) begin
                chk("lat_we_at_n1", 32'(mem_we), 1);
                chk("lat_ready_low_n1", 32'(byte_ready), 0);
                byte_valid = 1'b0;
                tick();
                chk("lat_we_drop_n2", 32'(mem_we), 0);
                chk("lat_ready_back_n2", 32'(byte_ready), 1);
            end
        end
`ifdef CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ bytes[8*i +: 8];
        send_byte(csum_corrupt ? (x ^ 8'h01) : x);
`endif
        byte_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        if (!done) begin
            bound_fail("done_pulse");
        end else begin
            chk("words_written_at_done", 32'(words_written), MAX_WORDS);
            chk("busy_at_done", 32'(busy), 0);
            chk("addr_after_session", 32'(mem_addr), 32'(5'(base + 5'd2)));
`ifdef CHECKSUM_EN
            chk("csum_err", 32'(csum_err), 32'(csum_corrupt));
`endif
            tick();
            chk("done_one_cycle", 32'(done), 0);
        end
        if (!gaps && !noise && !lat) chk("ready_low_cycles", 32'(stall_cnt), MAX_WORDS);
        chk("writes_outstanding", 32'(exp_q.size()), 0);
    endtask

    initial begin
        logic [7:0]  rb[8];
        logic [63:0] pk;
        logic [4:0]  rbase;
        logic [31:0] d;

        tbl[0] = '{base: 5'd3,  bytes: 64'hDEADBEEF_12345678,
                   a0: 5'd3,  w0: 32'h12345678, a1: 5'd4, w1: 32'hDEADBEEF};
        tbl[1] = '{base: 5'd31, bytes: 64'h0BADF00D_CAFEBABE,
                   a0: 5'd31, w0: 32'hCAFEBABE, a1: 5'd0, w1: 32'h0BADF00D};
        tbl[2] = '{base: 5'd0,  bytes: 64'h00000000_FFFFFFFF,
                   a0: 5'd0,  w0: 32'hFFFFFFFF, a1: 5'd1, w1: 32'h00000000};

        errors     = 0;
        checks     = 0;
        stall_cnt  = 0;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
`ifdef CHECKSUM_EN
        csum_corrupt = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_byte_ready", 32'(byte_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_words_written", 32'(words_written), 0);
`ifdef CHECKSUM_EN
        chk("rst_csum_err", 32'(csum_err), 0);
`endif

        // Bytes offered while idle are neither accepted nor written.
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_ready", 32'(byte_ready), 0);
        chk("idle_busy", 32'(busy), 0);
        byte_valid = 1'b0;

        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{a: tbl[k].a0, d: tbl[k].w0});
            exp_q.push_back('{a: tbl[k].a1, d: tbl[k].w1});
            run_session(tbl[k].base, tbl[k].bytes, 1'b0, k == 2, k == 0);
        end

        // Reset mid-word discards the partial word; the next session starts clean.
        start     = 1'b1;
        base_addr = 5'd10;
        tick();
        start = 1'b0;
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(byte_ready), 0);
        chk("midrst_addr", 32'(mem_addr), 0);
        exp_q.push_back('{a: 5'd10, d: 32'h44332211});
        start     = 1'b1;
        base_addr = 5'd10;
        tick();
        start = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("midrst_writes_left", 32'(exp_q.size()), 0);
        chk("midrst_words_written", 32'(words_written), 1);
        chk("midrst_addr_next", 32'(mem_addr), 11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Randomized sessions against the little-endian packing model.
        for (int s = 0; s < 20; s++) begin
            rbase = 5'($urandom);
            for (int i = 0; i < 8; i++) begin
                rb[i] = 8'($urandom);
                pk[8*i +: 8] = rb[i];
            end
            for (int w = 0; w < 2; w++) begin
                d = 32'(rb[4*w]) + 32'(rb[4*w+1]) * 256 + 32'(rb[4*w+2]) * 65536
                  + 32'(rb[4*w+3]) * 16777216;
                exp_q.push_back('{a: 5'(rbase + 5'(w)), d: d});
            end
            run_session(rbase, pk, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end

`ifdef CHECKSUM_EN
        exp_q.push_back('{a: 5'd6, d: 32'h08040201});
        exp_q.push_back('{a: 5'd7, d: 32'h00000000});
        csum_corrupt = 1'b0;
        run_session(5'd6, 64'h00000000_08040201, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{a: 5'd6, d: 32'h08040201});
        exp_q.push_back('{a: 5'd7, d: 32'h00000000});
        csum_corrupt = 1'b1;
        run_session(5'd6, 64'h00000000_08040201, 1'b0, 1'b0, 1'b0);
        tick();
        chk("csum_err_holds", 32'(csum_err), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
